// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART receiver.
// Holds the receiver FSM state type, the register window offsets and the bit positions
// used in the status and control registers.
// Optional build macro RX_FIFO_EN (used by uart_rx_mmio) turns the holding register into
// a small FIFO; FifoDepth sizes it.
package uart_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } rx_state_e;

   // Register offsets inside the 3-word window
   localparam logic [3:0] OffRxData = 4'h0;
   localparam logic [3:0] OffRxStat = 4'h4;
   localparam logic [3:0] OffRxCtrl = 4'h8;

   // RXSTAT bit positions
   localparam int unsigned StatValid    = 0;
   localparam int unsigned StatOverrun  = 1;
   localparam int unsigned StatFrameErr = 2;
   localparam int unsigned StatBusy     = 3;
   localparam int unsigned StatCntLsb   = 4;
   localparam int unsigned StatCntMsb   = 6;

   // RXCTRL bit positions
   localparam int unsigned CtrlEnable = 0;
   localparam int unsigned CtrlIrqEn  = 1;

   localparam int unsigned FifoDepth = 4;

   // True when a byte address falls on one of the three registers of the window.
   function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
      logic [31:0] off;
      off = addr - base;
      return (off < 32'd12) && (off[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial deserialiser: two-flop synchroniser, baud counter and receive FSM.
// Ports:
//   sysclk           - system clock, rising edge
//   reset            - synchronous active-high reset
//   rxd_i            - asynchronous serial input, idle high
//   enable_i         - receiver enable; dropping it aborts any frame in progress
//   byte_o           - last assembled byte (stable while byte_strb_o is high)
//   byte_strb_o      - one-cycle pulse: good stop bit, byte_o is a new byte
//   frame_err_strb_o - one-cycle pulse: stop bit sampled low, byte discarded
//   busy_o           - FSM is not idle
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 10416
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       rxd_i,
   input  logic       enable_i,
   output logic [7:0] byte_o,
   output logic       byte_strb_o,
   output logic       frame_err_strb_o,
   output logic       busy_o
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);

   logic            rx_meta_q;
   logic            rxs_q;
   rx_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;

   always_ff @(posedge sysclk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
      end else begin
         rx_meta_q <= rxd_i;
         rxs_q     <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      idx_d            = idx_q;
      shift_d          = shift_q;
      byte_strb_o      = 1'b0;
      frame_err_strb_o = 1'b0;

      if (!enable_i) begin
         // Abort: partial byte is simply never strobed out
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               cnt_d = '0;
               if (!rxs_q) state_d = StStart;
            end
            StStart: begin
               // Re-check the line at mid start bit to reject glitches
               if (cnt_q == HalfEnd) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = rxs_q ? StIdle : StData;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StData: begin
               if (cnt_q == BitEnd) begin
                  cnt_d          = '0;
                  shift_d[idx_q] = rxs_q;
                  if (idx_q == 3'd7) begin
                     state_d = StStop;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StStop: begin
               if (cnt_q == BitEnd) begin
                  cnt_d   = '0;
                  state_d = StIdle;
                  if (rxs_q) begin
                     byte_strb_o = 1'b1;
                  end else begin
                     frame_err_strb_o = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign byte_o = shift_q;
   assign busy_o = (state_q != StIdle);

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receiver on the CPU data-memory bus.
// Window at BASE_ADDR: +0 RXDATA (byte), +4 RXSTAT (valid/overrun/frame_err/busy/count),
// +8 RXCTRL (enable/irq_en). Read data is combinational so the MEM stage can use it in the
// same cycle; a load of RXDATA consumes the held byte at the clock edge.
// Build option: define RX_FIFO_EN to replace the single holding register with a 4-entry
// FIFO (RXSTAT[6:4] then reports occupancy; otherwise it reads 0).
// Ports:
//   sysclk, reset        - clock and synchronous active-high reset
//   addr, wdata          - MEM-stage byte address and store data
//   mem_read, mem_write  - one-cycle load / store strobes
//   rdata                - combinational read data, 0 when sel is low
//   sel                  - addr hits one of the three registers
//   uart_rxd             - asynchronous serial input, idle high
//   irq                  - registered valid & irq_en
module uart_rx_mmio
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 100000000,
   parameter int unsigned BAUD      = 9600,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [31:0] rdata,
   output logic        sel,
   input  logic        uart_rxd,
   output logic        irq
);

   // Must come out at 4 or more for the mid-bit sampling to make sense
   localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;

   logic [31:0] off;
   logic        pop_req;
   logic        wr_stat;
   logic        wr_ctrl;

   logic [7:0]  rx_byte;
   logic        byte_strb;
   logic        frame_err_strb;
   logic        busy;

   logic        enable_q, enable_d;
   logic        irq_en_q, irq_en_d;
   logic        overrun_q, overrun_d;
   logic        frame_err_q, frame_err_d;
   logic        irq_q, irq_d;

   logic        valid;
   logic        valid_next;
   logic        ovr_set;
   logic [7:0]  head;
   logic [2:0]  cnt_field;

   uart_rx_core #(
      .CLKS_PER_BIT (ClksPerBit)
   ) u_core (
      .sysclk           (sysclk),
      .reset            (reset),
      .rxd_i            (uart_rxd),
      .enable_i         (enable_q),
      .byte_o           (rx_byte),
      .byte_strb_o      (byte_strb),
      .frame_err_strb_o (frame_err_strb),
      .busy_o           (busy)
   );

   // Bus decode
   assign off     = addr - BASE_ADDR;
   assign sel     = in_window(addr, BASE_ADDR);
   assign pop_req = mem_read  & sel & (off[3:0] == OffRxData);
   assign wr_stat = mem_write & sel & (off[3:0] == OffRxStat);
   assign wr_ctrl = mem_write & sel & (off[3:0] == OffRxCtrl);

`ifdef RX_FIFO_EN
   logic [7:0] fifo_q [FifoDepth];
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [2:0] count_q, count_d;
   logic       full;
   logic       pop;
   logic       push;

   assign full  = (count_q == 3'(FifoDepth));
   assign valid = (count_q != 3'd0);
   assign pop   = pop_req & valid;
   // A pop in the same cycle frees the slot the new byte needs
   assign push    = byte_strb & (~full | pop);
   assign ovr_set = byte_strb & full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {1'b0, push};
      rd_ptr_d = rd_ptr_q + {1'b0, pop};
      count_d  = count_q + {2'b00, push} - {2'b00, pop};
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         for (int i = 0; i < FifoDepth; i++) fifo_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) fifo_q[wr_ptr_q] <= rx_byte;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign valid_next = (count_d != 3'd0);
   assign head       = fifo_q[rd_ptr_q];
   assign cnt_field  = count_q;
`else
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       deliver;

   // A load in the delivery cycle makes room, so the new byte replaces the old one
   assign deliver = byte_strb & (~valid_q | pop_req);
   assign ovr_set = byte_strb & valid_q & ~pop_req;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (deliver) begin
         data_d  = rx_byte;
         valid_d = 1'b1;
      end else if (pop_req) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign valid      = valid_q;
   assign valid_next = valid_d;
   assign head       = data_q;
   assign cnt_field  = 3'd0;
`endif

   // Control and sticky status; a sticky set beats a write-1-to-clear in the same cycle
   always_comb begin
      enable_d    = wr_ctrl ? wdata[CtrlEnable] : enable_q;
      irq_en_d    = wr_ctrl ? wdata[CtrlIrqEn]  : irq_en_q;
      overrun_d   = (overrun_q   & ~(wr_stat & wdata[StatOverrun]))  | ovr_set;
      frame_err_d = (frame_err_q & ~(wr_stat & wdata[StatFrameErr])) | frame_err_strb;
      // Built from next-state values so irq tracks valid & irq_en without extra lag
      irq_d       = valid_next & irq_en_d;
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         enable_q    <= 1'b1;
         irq_en_q    <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         enable_q    <= enable_d;
         irq_en_q    <= irq_en_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         irq_q       <= irq_d;
      end
   end

   assign irq = irq_q;

   // Combinational read mux
   always_comb begin
      rdata = '0;
      if (sel) begin
         unique case (off[3:0])
            OffRxData: rdata[7:0] = head;
            OffRxStat: begin
               rdata[StatValid]                = valid;
               rdata[StatOverrun]              = overrun_q;
               rdata[StatFrameErr]             = frame_err_q;
               rdata[StatBusy]                 = busy;
               rdata[StatCntMsb:StatCntLsb]    = cnt_field;
            end
            OffRxCtrl: begin
               rdata[CtrlEnable] = enable_q;
               rdata[CtrlIrqEn]  = irq_en_q;
            end
            default: rdata = '0;
         endcase
      end
   end

   // Upper store-data bits carry no meaning for this block
   logic unused_wdata;
   assign unused_wdata = ^wdata[31:3];

endmodule

// File: tb/tb_uart_rx_mmio.sv
module tb_uart_rx_mmio;

   localparam int unsigned ClkFreq = 1000000;
   localparam int unsigned Baud    = 100000;
   localparam int unsigned Cpb     = ClkFreq / Baud;
   localparam logic [31:0] Base    = 32'h4000_0018;
`ifdef RX_FIFO_EN
   localparam int Depth = 4;
`else
   localparam int Depth = 1;
`endif

   logic        sysclk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] rdata;
   logic        sel;
   logic        uart_rxd;
   logic        irq;

   int total = 0;
   int bad   = 0;

   // Reference model: received bytes awaiting loads, plus sticky flags and control bits
   logic [7:0] q[$];
   bit         m_ovr;
   bit         m_ferr;
   bit         m_irqen;

   uart_rx_mmio #(
      .CLK_FREQ  (ClkFreq),
      .BAUD      (Baud),
      .BASE_ADDR (Base)
   ) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .rdata     (rdata),
      .sel       (sel),
      .uart_rxd  (uart_rxd),
      .irq       (irq)
   );

   always #5 sysclk = ~sysclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_stat();
      logic [31:0] s;
      s    = '0;
      s[0] = (q.size() != 0);
      s[1] = m_ovr;
      s[2] = m_ferr;
`ifdef RX_FIFO_EN
      s[6:4] = 3'(q.size());
`endif
      return s;
   endfunction

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic model_reset();
      q.delete();
      m_ovr   = 0;
      m_ferr  = 0;
      m_irqen = 0;
   endtask

   task automatic model_deliver(input logic [7:0] b);
      if (q.size() < Depth) q.push_back(b);
      else m_ovr = 1;
   endtask

   task automatic chk_stat(input string tag);
      @(negedge sysclk);
      chk(tag, rdata, exp_stat());
      tick();
   endtask

   task automatic chk_irq(input string tag);
      @(negedge sysclk);
      chk(tag, {31'b0, irq}, {31'b0, (q.size() != 0) && m_irqen});
      tick();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr      = a;
      wdata     = d;
      mem_write = 1'b1;
      tick();
      mem_write = 1'b0;
      addr      = Base + 32'd4;
   endtask

   task automatic load(output logic [31:0] d);
      addr     = Base;
      mem_read = 1'b1;
      #1;
      d = rdata;
      tick();
      mem_read = 1'b0;
      addr     = Base + 32'd4;
   endtask

   task automatic check_load(input string tag);
      logic [31:0] d;
      logic [7:0]  e;
      load(d);
      if (q.size() != 0) begin
         e = q.pop_front();
         chk(tag, d, {24'b0, e});
      end
   endtask

   task automatic chk_ctrl(input string tag, input logic [31:0] exp);
      addr = Base + 32'd8;
      @(negedge sysclk);
      chk(tag, rdata, exp);
      tick();
      addr = Base + 32'd4;
   endtask

   // Drives one frame starting now; n counts clock edges after the start-bit fall.
   // v98 reports RXSTAT.valid right after the 98th edge. With timed_load the RXDATA
   // load is held over exactly the 98th edge, where the stop bit is sampled.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit timed_load,
                             output bit v98);
      logic [9:0] bits;
      int         n;
      bits = {stop_ok, b, 1'b0};
      n    = 0;
      v98  = 0;
      for (int i = 0; i < 10; i++) begin
         uart_rxd = bits[i];
         for (int c = 0; c < int'(Cpb); c++) begin
            tick();
            n++;
            if (timed_load && n == 97) begin
               addr     = Base;
               mem_read = 1'b1;
               #1;
               chk("t6_load_old", rdata, {24'b0, q[0]});
            end
            if (n == 98) begin
               if (timed_load) begin
                  mem_read = 1'b0;
                  addr     = Base + 32'd4;
               end
               #1;
               v98 = rdata[0];
            end
         end
      end
      uart_rxd = 1'b1;
      repeat (12) tick();
   endtask

   initial begin
      bit          v;
      logic [7:0]  b;
      logic [7:0]  e;
      bit          ok;
      logic [31:0] d;

      reset     = 1'b1;
      uart_rxd  = 1'b1;
      addr      = Base + 32'd4;
      wdata     = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      model_reset();
      repeat (3) tick();
      reset = 1'b0;

      // Reset state and decode
      chk_stat("reset_stat");
      chk_ctrl("reset_ctrl", 32'h1);
      chk_irq("reset_irq");
      addr = Base;
      @(negedge sysclk);
      chk("reset_data", rdata, 32'h0);
      chk("sel_base", {31'b0, sel}, 32'h1);
      addr = Base + 32'd12;
      @(negedge sysclk);
      chk("sel_past_end", {31'b0, sel}, 32'h0);
      chk("rdata_unsel", rdata, 32'h0);
      addr = Base + 32'd2;
      @(negedge sysclk);
      chk("sel_unaligned", {31'b0, sel}, 32'h0);
      addr = Base - 32'd4;
      @(negedge sysclk);
      chk("sel_below", {31'b0, sel}, 32'h0);
      tick();
      addr = Base + 32'd4;

      // 1: single byte, latency bound, load clears valid
      send_frame(8'hA5, 1'b1, 1'b0, v);
      model_deliver(8'hA5);
      chk("t1_latency_valid", {31'b0, v}, 32'h1);
      check_load("t1_data");
      chk_stat("t1_stat_after_load");

      // 2: two bytes, no load in between
      send_frame(8'h3C, 1'b1, 1'b0, v);
      model_deliver(8'h3C);
      send_frame(8'h7E, 1'b1, 1'b0, v);
      model_deliver(8'h7E);
      chk_stat("t2_stat_two");
      addr = Base;
      @(negedge sysclk);
      chk("t2_peek_data", rdata, {24'b0, q[0]});
      tick();
      wr(Base + 32'd4, 32'h2);
      m_ovr = 0;
      chk_stat("t2_stat_w1c");
      while (q.size() != 0) check_load("t2_drain");
      chk_stat("t2_stat_empty");

      // 3: frame error
      send_frame(8'h55, 1'b0, 1'b0, v);
      m_ferr = 1;
      chk_stat("t3_stat_ferr");
      wr(Base + 32'd4, 32'h4);
      m_ferr = 0;
      chk_stat("t3_stat_cleared");

      // 4: short low glitch is rejected
      uart_rxd = 1'b0;
      repeat (3) tick();
      uart_rxd = 1'b1;
      @(negedge sysclk);
      chk("t4_busy_glitch", {31'b0, rdata[3]}, 32'h1);
      tick();
      repeat (15) tick();
      chk_stat("t4_stat_after");

      // 5: interrupt
      wr(Base + 32'd8, 32'h3);
      m_irqen = 1;
      send_frame(8'h01, 1'b1, 1'b0, v);
      model_deliver(8'h01);
      chk_irq("t5_irq_set");
      check_load("t5_data");
      @(negedge sysclk);
      chk("t5_irq_clear", {31'b0, irq}, 32'h0);
      tick();

      // 5b: disable mid-frame
      uart_rxd = 1'b0;
      repeat (30) tick();
      @(negedge sysclk);
      chk("t5_busy_mid", {31'b0, rdata[3]}, 32'h1);
      tick();
      wr(Base + 32'd8, 32'h0);
      m_irqen = 0;
      tick();
      @(negedge sysclk);
      chk("t5_busy_disabled", {31'b0, rdata[3]}, 32'h0);
      tick();
      repeat (70) tick();
      uart_rxd = 1'b1;
      repeat (15) tick();
      chk_stat("t5_stat_disabled");
      chk_ctrl("t5_ctrl_off", 32'h0);
      wr(Base + 32'd8, 32'h1);
      chk_ctrl("t5_ctrl_on", 32'h1);

      // 6: load coincident with delivery of the second byte
      send_frame(8'hC3, 1'b1, 1'b0, v);
      model_deliver(8'hC3);
      send_frame(8'h96, 1'b1, 1'b1, v);
      e = q.pop_front();
      model_deliver(8'h96);
      chk_stat("t6_stat_coincide");
      check_load("t6_data_new");
      chk_stat("t6_stat_empty");

      // 6b: five bytes without loads
      for (int k = 0; k < 5; k++) begin
         b = 8'(8'h10 + k * 8'h11);
         send_frame(b, 1'b1, 1'b0, v);
         model_deliver(b);
      end
      chk_stat("t6_stat_five");
      while (q.size() != 0) check_load("t6_pop_order");
      wr(Base + 32'd4, 32'h2);
      m_ovr = 0;
      chk_stat("t6_stat_clean");

      // Randomized traffic against the model
      wr(Base + 32'd8, 32'h3);
      m_irqen = 1;
      for (int k = 0; k < 12; k++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(0, 5) != 0);
         send_frame(b, ok, 1'b0, v);
         if (ok) model_deliver(b);
         else m_ferr = 1;
         chk_stat("rnd_stat");
         chk_irq("rnd_irq");
         if ($urandom_range(0, 2) == 0) begin
            check_load("rnd_data");
            chk_stat("rnd_stat_load");
         end
         if ($urandom_range(0, 3) == 0) begin
            wr(Base + 32'd4, 32'h6);
            m_ovr  = 0;
            m_ferr = 0;
            chk_stat("rnd_stat_w1c");
         end
      end
      while (q.size() != 0) check_load("rnd_drain");
      wr(Base + 32'd4, 32'h6);
      m_ovr  = 0;
      m_ferr = 0;
      chk_stat("rnd_stat_final");
      chk_irq("rnd_irq_final");

      // Reset mid-frame
      uart_rxd = 1'b0;
      repeat (40) tick();
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      uart_rxd = 1'b1;
      model_reset();
      repeat (15) tick();
      chk_stat("rst_mid_stat");
      chk_ctrl("rst_mid_ctrl", 32'h1);
      load(d);
      chk("rst_mid_data", d, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
